// File: rtl/bpf_update_queue.sv
// Branch-resolve update queue.
// Picks the live resolve lanes, raises a registered frontend redirect on a
// CSR request or on the oldest live mispredict, and buffers the predictor
// training updates in a small first-word-fall-through FIFO that accepts up
// to LANES writes per cycle and drains one entry per accepted handshake.
module bpf_update_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int PCW   = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      csr_flush_i,
    input  logic [PCW-1:0]            csr_target_i,
    input  logic                      stall_i,
    input  logic [LANES-1:0]          lane_valid_i,
    input  logic [LANES-1:0][PCW-1:0] lane_pc_i,
    input  logic [LANES-1:0]          lane_taken_i,
    input  logic [LANES-1:0][PCW-1:0] lane_target_i,
    input  logic [LANES-1:0]          lane_pred_taken_i,
    input  logic [LANES-1:0][PCW-1:0] lane_pred_npc_i,
    input  logic [LANES-1:0][1:0]     lane_br_type_i,
    output logic                      ready_o,
    output logic                      flush_o,
    output logic [PCW-1:0]            flush_target_o,
    output logic                      upd_valid_o,
    input  logic                      upd_ready_i,
    output logic [PCW-1:0]            upd_pc_o,
    output logic                      upd_taken_o,
    output logic [PCW-1:0]            upd_target_o,
    output logic [1:0]                upd_br_type_o,
    output logic                      upd_miss_o,
    output logic [31:0]               miss_cnt_o
);

    // A one-entry FIFO still needs a one-bit pointer; masking by DEPTH-1
    // keeps the wrap correct for every power-of-two depth.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
        logic [PCW-1:0] target;
        logic [1:0]     br_type;
        logic           miss;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            flush_q, flush_d;
    logic [PCW-1:0]  flush_target_q, flush_target_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    logic [LANES-1:0] lane_miss;
    logic [LANES-1:0] live;
    logic [AW-1:0]    wr_idx [LANES];
    logic [CW-1:0]    push_cnt;
    logic             any_miss;
    logic [PCW-1:0]   miss_npc;
    logic             blocked;
    logic             pop;

    // Ready depends only on the registered occupancy so the BPU handshake
    // never reaches back into the resolve stage combinationally.
    assign ready_o = (CW'(DEPTH) - count_q) >= CW'(LANES);
    assign pop     = (count_q != '0) && upd_ready_i;

    // Lane qualification in age order: the first live mispredict blocks all
    // younger lanes, and each live lane gets the next free FIFO slot.
    always_comb begin
        int off;
        off      = 0;
        blocked  = 1'b0;
        live     = '0;
        lane_miss = '0;
        any_miss = 1'b0;
        miss_npc = '0;
        push_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_idx[k] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            lane_miss[k] = (lane_pred_taken_i[k] != lane_taken_i[k]) ||
                           (lane_taken_i[k] && (lane_pred_npc_i[k] != lane_target_i[k]));
            if (lane_valid_i[k] && !stall_i && !csr_flush_i && ready_o && !blocked) begin
                live[k]   = 1'b1;
                wr_idx[k] = AW'((int'(wr_ptr_q) + off) & (DEPTH - 1));
                off       = off + 1;
                push_cnt  = push_cnt + CW'(1);
                if (lane_miss[k]) begin
                    blocked  = 1'b1;
                    any_miss = 1'b1;
                    miss_npc = lane_taken_i[k] ? lane_target_i[k] : lane_pc_i[k] + PCW'(1);
                end
            end
        end
    end

    // Next-state for pointers, occupancy, redirect and the mispredict counter.
    always_comb begin
        wr_ptr_d       = AW'((int'(wr_ptr_q) + int'(push_cnt)) & (DEPTH - 1));
        rd_ptr_d       = pop ? AW'((int'(rd_ptr_q) + 1) & (DEPTH - 1)) : rd_ptr_q;
        count_d        = count_q + push_cnt - CW'(pop);
        flush_d        = csr_flush_i || any_miss;
        flush_target_d = flush_target_q;
        if (csr_flush_i) begin
            flush_target_d = csr_target_i;
        end else if (any_miss) begin
            flush_target_d = miss_npc;
        end
        miss_cnt_d = miss_cnt_q;
        if (any_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
            miss_cnt_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (live[k]) begin
                mem_q[wr_idx[k]] <= '{pc:      lane_pc_i[k],
                                      taken:   lane_taken_i[k],
                                      target:  lane_target_i[k],
                                      br_type: lane_br_type_i[k],
                                      miss:    lane_miss[k]};
            end
        end
    end

    assign flush_o        = flush_q;
    assign flush_target_o = flush_target_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign upd_valid_o    = (count_q != '0);
    assign upd_pc_o       = mem_q[rd_ptr_q].pc;
    assign upd_taken_o    = mem_q[rd_ptr_q].taken;
    assign upd_target_o   = mem_q[rd_ptr_q].target;
    assign upd_br_type_o  = mem_q[rd_ptr_q].br_type;
    assign upd_miss_o     = mem_q[rd_ptr_q].miss;

endmodule
